// File: rtl/mmio_hub_if.sv
`default_nettype none
// ============================================================================
// Module   : mmio_hub_if
// Brief    : MEM-stage request/response bus between the core and mmio_hub.
// Revision : 1.0 - initial release
// ============================================================================
interface mmio_hub_if #(
    parameter int DATA_W = 32
) ();
    logic                  req_valid;
    logic                  req_write;
    logic [31:0]           req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_be;
    logic [DATA_W-1:0]     rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be,
        input  rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be,
        output rdata
    );
endinterface
`default_nettype wire

// File: rtl/mmio_hub.sv
`default_nettype none
// ============================================================================
// Module   : mmio_hub
// Brief    : MMIO decode for the MEM stage: BRAM gating, byte-writable output
//            registers and FIFO-buffered input channels with interrupts.
// Revision : 1.0 - initial release
// ============================================================================
module mmio_hub #(
    parameter int DATA_W     = 32,
    parameter int N_IN       = 2,
    parameter int N_OUT      = 2,
    parameter int OUT_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    mmio_hub_if.slave                     bus,
    input  wire logic [DATA_W-1:0]        bram_rdata,
    output logic      [DATA_W/8-1:0]      bram_we,
    input  wire logic [N_IN*DATA_W-1:0]   in_data,
    input  wire logic [N_IN-1:0]          in_valid,
    output logic      [N_OUT*OUT_W-1:0]   out_regs,
    output logic      [N_OUT-1:0]         out_wr,
    output logic                          irq
);
    localparam int c_OUT_BYTES = OUT_W / 8;
    localparam int c_PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W     = c_PTR_W + 1;

    logic [3:0]               w_region;
    logic [5:0]               w_out_idx;
    logic [3:0]               w_ch;
    logic [1:0]               w_reg;
    logic                     w_load;
    logic                     w_store;
    logic [N_OUT*DATA_W-1:0]  w_out_rd;
    logic [N_IN*DATA_W-1:0]   w_ch_rd;
    logic [N_IN-1:0]          w_irq_ch;
    logic [DATA_W-1:0]        w_load_data;
    logic                     r_rd_bram;
    logic [DATA_W-1:0]        r_rd_hold;
    logic                     w_unused;

    assign w_region  = bus.req_addr[31:28];
    assign w_out_idx = bus.req_addr[7:2];
    assign w_ch      = bus.req_addr[11:8];
    assign w_reg     = bus.req_addr[3:2];
    assign w_load    = bus.req_valid & ~bus.req_write;
    assign w_store   = bus.req_valid &  bus.req_write;
    assign w_unused  = ^{bus.req_addr[27:12], bus.req_addr[1:0], bus.req_wdata};

    assign bram_we = (w_store && (w_region == 4'h0)) ? bus.req_be : '0;

    for (genvar j = 0; j < N_OUT; j++) begin : g_out
        logic [OUT_W-1:0] r_val;
        logic             r_wr;
        logic             w_hit;

        assign w_hit = w_store && (w_region == 4'h2) && (w_out_idx == 6'(j));

        always_ff @(posedge clk) begin
            if (rst) begin
                r_val <= '0;
                r_wr  <= 1'b0;
            end else begin
                r_wr <= w_hit;
                for (int b = 0; b < c_OUT_BYTES; b++) begin
                    if (w_hit && bus.req_be[b]) begin
                        r_val[b*8 +: 8] <= bus.req_wdata[b*8 +: 8];
                    end
                end
            end
        end

        assign out_regs[j*OUT_W +: OUT_W]  = r_val;
        assign out_wr[j]                   = r_wr;
        assign w_out_rd[j*DATA_W +: DATA_W] = DATA_W'(r_val);
    end

    for (genvar i = 0; i < N_IN; i++) begin : g_in
        logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
        logic [c_PTR_W-1:0] r_wptr;
        logic [c_PTR_W-1:0] r_rptr;
        logic [c_CNT_W-1:0] r_count;
        logic [7:0]         r_ovf;
        logic               r_irq_en;
        logic               w_sel, w_empty, w_full, w_pop, w_clr, w_ctrl;
        logic               w_flush, w_push, w_drop;
        logic [31:0]        w_status;
        logic [DATA_W-1:0]  w_rd;

        assign w_sel   = bus.req_valid && (w_region == 4'h3) && (w_ch == 4'(i));
        assign w_empty = (r_count == '0);
        assign w_full  = (r_count == c_CNT_W'(FIFO_DEPTH));
        assign w_pop   = w_sel && !bus.req_write && (w_reg == 2'd0) && !w_empty;
        assign w_clr   = w_sel &&  bus.req_write && (w_reg == 2'd1);
        assign w_ctrl  = w_sel &&  bus.req_write && (w_reg == 2'd2);
        assign w_flush = w_ctrl && bus.req_wdata[0];
        // A pop in the same cycle frees the slot, so a push on full still lands.
        assign w_push  = in_valid[i] && (!w_full || w_pop) && !w_flush;
        assign w_drop  = in_valid[i] &&   w_full && !w_pop  && !w_flush;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_wptr   <= '0;
                r_rptr   <= '0;
                r_count  <= '0;
                r_ovf    <= '0;
                r_irq_en <= 1'b0;
            end else begin
                if (w_flush) begin
                    r_wptr  <= '0;
                    r_rptr  <= '0;
                    r_count <= '0;
                end else begin
                    if (w_push) r_wptr <= r_wptr + 1'b1;
                    if (w_pop)  r_rptr <= r_rptr + 1'b1;
                    r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
                end
                if (w_clr) begin
                    r_ovf <= '0;
                end else if (w_drop && (r_ovf != 8'hFF)) begin
                    r_ovf <= r_ovf + 8'd1;
                end
                if (w_ctrl) r_irq_en <= bus.req_wdata[1];
            end
        end

        always_ff @(posedge clk) begin
            if (!rst && w_push) begin
                r_mem[r_wptr] <= in_data[i*DATA_W +: DATA_W];
            end
        end

        assign w_status = {8'h00, r_ovf, 8'(r_count), 6'h00, w_full, w_empty};

        always_comb begin
            w_rd = '0;
            case (w_reg)
                2'd0:    w_rd = w_empty ? '0 : r_mem[r_rptr];
                2'd1:    w_rd = DATA_W'(w_status);
                2'd2:    w_rd = DATA_W'({r_irq_en, 1'b0});
                default: w_rd = '0;
            endcase
        end

        assign w_ch_rd[i*DATA_W +: DATA_W] = w_rd;
        assign w_irq_ch[i] = r_irq_en & ~w_empty;
    end

    assign irq = |w_irq_ch;

    always_comb begin
        w_load_data = '0;
        for (int j = 0; j < N_OUT; j++) begin
            if ((w_region == 4'h2) && (w_out_idx == 6'(j))) begin
                w_load_data = w_out_rd[j*DATA_W +: DATA_W];
            end
        end
        for (int i = 0; i < N_IN; i++) begin
            if ((w_region == 4'h3) && (w_ch == 4'(i))) begin
                w_load_data = w_ch_rd[i*DATA_W +: DATA_W];
            end
        end
    end

    // BRAM data is only valid for one cycle; capture it so rdata holds afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_bram <= 1'b0;
            r_rd_hold <= '0;
        end else begin
            r_rd_bram <= w_load && (w_region == 4'h0);
            if (w_load && (w_region != 4'h0)) begin
                r_rd_hold <= w_load_data;
            end else if (r_rd_bram) begin
                r_rd_hold <= bram_rdata;
            end
        end
    end

    assign bus.rdata = r_rd_bram ? bram_rdata : r_rd_hold;
endmodule
`default_nettype wire

// File: doc/mmio_hub.md
Name: mmio_hub

Overview:
Parametrised MMIO controller for the 5-stage RISC-V core's MEM stage. It replaces the fixed single-register LED/PS2/number-buffer decode with N_IN buffered input channels and N_OUT byte-writable output registers. Each input channel has a FIFO, status, overflow counting and an interrupt enable. It also gates BRAM writes and muxes BRAM read data, keeping the one-cycle load latency the pipeline's MEM/WB register expects.

Parameters:
DATA_W, 32, CPU data width (multiple of 8)
N_IN, 2, number of input channels (1..16)
N_OUT, 2, number of output registers (1..64)
OUT_W, 16, output register width (8..DATA_W, multiple of 8)
FIFO_DEPTH, 4, entries per input FIFO (power of 2, 2..128)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
req_valid  in  1  MEM-stage access this cycle
req_write  in  1  1 = store, 0 = load
req_addr  in  32  byte address (EX/MEM ALU result)
req_wdata  in  DATA_W  store data
req_be  in  DATA_W/8  store byte enables
bram_rdata  in  DATA_W  BRAM port-B read data (valid one cycle after address)
bram_we  out  DATA_W/8  BRAM port-B byte write enables (combinational)
rdata  out  DATA_W  load data, valid the cycle after req_valid
in_data  in  N_IN*DATA_W  channel i data at slice [i*DATA_W +: DATA_W]
in_valid  in  N_IN  one-cycle push strobe per channel
out_regs  out  N_OUT*OUT_W  output register contents (e.g. LED, VGA result)
out_wr  out  N_OUT  one-cycle pulse, the cycle after an output register is written
irq  out  1  OR over channels of (irq_en & !empty)

Behaviour:
- One clock, clk. rst is synchronous and active-high.
- Reset: all FIFOs empty with pointers at 0. Overflow counters, irq_en, out_regs, out_wr and rdata are 0. bram_we is 0 whenever req_valid=0.
- Decode on req_addr[31:28]:
  - 0x0 = BRAM.
  - 0x2 = output register, index = req_addr[7:2].
  - 0x3 = input channel, ch = req_addr[11:8], reg = req_addr[3:2].
  - Anything else = unmapped.
- BRAM:
  - bram_we = req_be when req_valid & req_write & region 0, else 0.
  - Load: rdata = bram_rdata, selected by a registered region flag.
- Output register (index < N_OUT):
  - Store updates bytes b < OUT_W/8 with req_be[b]=1.
  - out_wr[index] pulses high on the next cycle.
  - Load returns the value zero-extended to DATA_W.
  - Index >= N_OUT: store ignored, load returns 0.
- Input channel (ch < N_IN; ch >= N_IN is unmapped):
  - reg 0 DATA: load returns FIFO head and pops one entry. Load on empty returns 0 with no state change. Store is ignored.
  - reg 1 STATUS, load: bit0 empty, bit1 full, [15:8] occupancy, [23:16] overflow count, rest 0.
  - reg 1 STATUS, store of any value: clears the overflow count.
  - reg 2 CTRL, store: bit0 = flush (self-clearing), bit1 = irq_en.
  - reg 2 CTRL, load: {30'b0, irq_en, 1'b0}.
  - reg 3: load 0, store ignored.
- Unmapped region: load returns 0, store ignored.
- MMIO loads: rdata registered from the pre-pop state of the request cycle.
- MMIO side effects (pop, clear, flush) take effect at the end of the request cycle.
- FIFO push:
  - in_valid[i] pushes in_data channel i.
  - Push on full without a same-cycle pop: data dropped; overflow counter +1, saturating at 255.
  - Push and pop in the same cycle: both occur, at any occupancy including full (occupancy unchanged, no overflow) and empty (pop returns 0, pushed word is stored, occupancy 1).
- Flush: flush wins over a same-cycle push. The FIFO ends empty, the push is discarded and not counted as overflow.
- STATUS clear with a same-cycle overflow: clear wins, counter ends at 0.
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo depth. Occupancy counter is log2(FIFO_DEPTH)+1 bits.
- irq is combinational from registered state.
- req_valid=0 means no side effects; rdata holds its last value.
- rst asserted mid-operation overrides all same-cycle pushes, pops and writes.

Test Plan:
- Reset: apply rst 2 cycles -> out_regs=0, irq=0, rdata=0; STATUS of ch0 reads 0x00000001.
- Output write: store 0xABCD1234, be=4'b0001, addr 0x20000004 -> out_regs[1]=0x0034, out_wr=2'b10 for one cycle. Load the same address -> rdata=0x00000034.
- FIFO order and overflow (FIFO_DEPTH=4): push 0x1C,0x32,0x21,0x23,0x24 on ch0 -> STATUS=0x00010402. Four DATA loads (0x30000000) return 0x1C,0x32,0x21,0x23; a fifth load returns 0 and STATUS=0x00010001.
- Simultaneous push+pop on full: ch1 holds 1,2,3,4. DATA load on 0x30000100 with in_valid[1]=1, data 5 -> rdata=1, occupancy stays 4. Subsequent loads return 2,3,4,5.
- Flush and irq: write CTRL=0x2 on ch0, push 0x7 -> irq=1. Write CTRL=0x3 with a same-cycle push -> FIFO empty, irq=0, overflow unchanged.
- BRAM path: store be=4'hF to 0x00000010 -> bram_we=4'hF for that cycle. Load 0x00000010 with bram_rdata=0xDEADBEEF next cycle -> rdata=0xDEADBEEF. Load 0x40000000 -> rdata=0.
